// File: rtl/rcon_sequencer_pkg.sv
// Shared definitions for the AES-128 round-constant sequencer:
// FSM state encoding, AES reduction constant, default constants, round width
// and the forward/inverse xtime helpers.
package rcon_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] AES_POLY      = 8'h1b;
  localparam logic [7:0] RCON_INIT_DEF = 8'h01;
  localparam logic [7:0] RCON_LAST_DEF = 8'h36;
  localparam int         ROUND_W       = 4;

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? AES_POLY : 8'h00);
  endfunction

  // Divide by x in GF(2^8): undoes xtime, used to walk the constants backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ AES_POLY) >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/rcon_step.sv
// Combinational next-constant generator for the round-constant sequencer.
// Optional macro RCON_INVERSE_EN adds the inv select and the inverse step.
module rcon_step
  import rcon_sequencer_pkg::*;
(
  input  logic [7:0] din,
`ifdef RCON_INVERSE_EN
  input  logic       inv,
`endif
  output logic [7:0] dout
);

  // Select forward (or, when built in, inverse) step of the current constant.
  always_comb begin
    dout = 8'h00;
`ifdef RCON_INVERSE_EN
    if (inv) begin
      dout = inv_xtime(din);
    end else begin
      dout = xtime(din);
    end
`else
    dout = xtime(din);
`endif
  end

endmodule

// File: rtl/rcon_sequencer.sv
// AES-128 key-schedule round-constant sequencer: emits NROUNDS constants,
// one per accepted handshake, then pulses done for one cycle.
// Optional macro RCON_INVERSE_EN adds the inv port to run the sequence backwards.
module rcon_sequencer
  import rcon_sequencer_pkg::*;
#(
  parameter int         NROUNDS   = 10,
  parameter logic [7:0] RCON_INIT = RCON_INIT_DEF,
  parameter logic [7:0] RCON_LAST = RCON_LAST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef RCON_INVERSE_EN
  input  logic               inv,
`endif
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         rcon,
  output logic [ROUND_W-1:0] round,
  output logic               last,
  output logic               done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NROUNDS - 1);

  state_t     state;
  logic       start_inv;
  logic [7:0] start_val;
  logic [7:0] rcon_next;

`ifdef RCON_INVERSE_EN
  logic inv_q;

  assign start_inv = inv;

  rcon_step u_step (
    .din  (rcon),
    .inv  (inv_q),
    .dout (rcon_next)
  );
`else
  // Direction is fixed forward in this build; the inverse start value is never chosen.
  assign start_inv = 1'b0;

  rcon_step u_step (
    .din  (rcon),
    .dout (rcon_next)
  );
`endif

  // First constant of a run depends on the direction sampled with start.
  always_comb begin
    if (start_inv) begin
      start_val = RCON_LAST;
    end else begin
      start_val = RCON_INIT;
    end
  end

  // Sequencer FSM with registered outputs; rcon is forced to zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      rcon      <= 8'h00;
      round     <= '0;
      last      <= 1'b0;
      done      <= 1'b0;
`ifdef RCON_INVERSE_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            rcon      <= start_val;
            round     <= '0;
            last      <= (LAST_ROUND == '0);
`ifdef RCON_INVERSE_EN
            inv_q     <= inv;
`endif
          end
        end
        ST_RUN: begin
          if (out_valid && out_ready) begin
            if (round == LAST_ROUND) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              rcon      <= 8'h00;
              round     <= '0;
              last      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rcon  <= rcon_next;
              round <= round + ROUND_W'(1);
              last  <= ((round + ROUND_W'(1)) == LAST_ROUND);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          rcon      <= 8'h00;
          round     <= '0;
          last      <= 1'b0;
        end
      endcase
    end
  end

endmodule
